fcvt_round_stage: RTL and testbench
===================================

// Module: fcvt_round_stage
// PURPOSE
//  Rounding/packing stage that sits directly downstream of the int->FP conversion datapath (FCVT.D.L/LU, FCVT.S.L/LU).
//  Accepts the converter's sign, biased exponent and 64-bit normalized significand.
//  Applies the RISC-V rounding mode and packs an IEEE-754 result plus the NX flag.
//  2-stage pipeline with valid/ready backpressure toward the FPU writeback.
// PARAMETERS
//  EXP_W   11  width of incoming biased exponent (double bias 1023)
//  MANT_W  64  width of incoming normalized significand (bit MANT_W-1 is the hidden 1)
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   upstream converter result valid
//  in_ready   out  1   stage can accept this cycle
//  in_sign    in   1   result sign
//  in_exp     in   11  biased exponent (double bias)
//  in_mant    in   64  normalized significand; in_mant[63]=1 unless in_zero
//  in_zero    in   1   integer source was 0
//  in_rm      in   3   rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 illegal
//  out_valid  out  1   result valid
//  out_ready  in   1   downstream accepts
//  out_fp     out  64  packed result
//  out_nx     out  1   inexact flag
//  out_ill    out  1   illegal rounding mode
// BEHAVIOUR
//  - Reset: out_valid=0, out_fp=0, out_nx=0, out_ill=0, both stage valids cleared; in_ready=1 the cycle after reset deasserts.
//  - Pipeline: S1 captures inputs and computes G/S/lsb and inc; S2 adds inc and packs. Latency 2 cycles with no stall.
//  - Handshake: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational from out_ready).
//  - Transfer happens only on valid&ready. Stalled stages hold all data bits. Order is preserved. Full throughput is 1/cycle.
//  - Double: kept = in_mant[62:11], lsb = in_mant[11], G = in_mant[10], S = |in_mant[9:0].
//  - inc rules: RNE G&(S|lsb); RTZ 0; RDN (G|S)&sign; RUP (G|S)&!sign; RMM G.
//  - NX = G|S, or 0 when in_zero.
//  - Carry: kept all ones plus inc gives kept=0 and exp+1 (53-bit add, use the carry). No overflow is reachable for 64-bit sources.
//  - in_zero: out_fp = 0x0000_0000_0000_0000 (+0), NX=0, regardless of sign or rm.
//  - in_rm 5..7: out_ill=1, out_fp=0, out_nx=0. The transaction still flows through the pipeline.
//  - Simultaneous in accept and out drain while full: both happen in the same cycle with no bubble.
//  - rst mid-operation flushes in-flight results; none are emitted.
// CONFIGURATION
//  FCVT_ROUND_SP_EN defined:
//   - adds port in_fmt (in, 1; 0=double, 1=single), carried with the data.
//   - Single: kept = in_mant[62:40], lsb = in_mant[40], G = in_mant[39], S = |in_mant[38:0].
//   - Single exponent = in_exp-1023+127 (8 bits).
//   - out_fp = {32'hFFFF_FFFF, packed single} (NaN-boxed).
//  FCVT_ROUND_SP_EN undefined: no in_fmt port; double only.
// TESTING
//  - Test 1: sign=0, exp=1023, mant=0x8000_0000_0000_0000, RNE -> out_fp=0x3FF0_0000_0000_0000, nx=0, out_valid 2 cycles after accept.
//  - Test 2: sign=1, same exp/mant -> 0xBFF0_0000_0000_0000.
//  - Test 3: exp=1076, mant=0x8000_0000_0000_0400 (2^53+1):
//    - RNE -> 0x4340_0000_0000_0000, nx=1
//    - RUP -> 0x4340_0000_0000_0001, nx=1
//  - Test 4: exp=1086, mant=0xFFFF_FFFF_FFFF_FFFF (2^64-1):
//    - RNE -> 0x43F0_0000_0000_0000 (carry into exponent), nx=1
//    - RTZ -> 0x43EF_FFFF_FFFF_FFFF, nx=1
//  - Test 5: in_zero=1 -> 0x0; in_rm=5 -> out_ill=1, out_fp=0.
//  - Test 6: stream 4 back-to-back inputs, hold out_ready=0 for 3 cycles.
//    - in_ready drops once both stages are full; outputs stay stable.
//    - After release, all 4 results emerge in order with no loss or duplicates.
//    - Assert rst mid-stream -> out_valid=0 next cycle, no stale output.
//  - SP build: exp=1023, mant=0x8000_0000_0000_0000, in_fmt=1 -> 0xFFFF_FFFF_3F80_0000.

Source files
------------

// File: rtl/fcvt_round_stage.sv
// ---------------------------------------------------------------------------
// fcvt_round_stage
//   Rounding/packing stage behind the int->FP converter (FCVT.D.L/LU,
//   FCVT.S.L/LU). Takes sign, double-biased exponent and a normalized
//   significand (hidden 1 at the top bit), applies the RISC-V rounding mode
//   and emits a packed IEEE-754 result with the inexact flag.
//
//   Two register stages with valid/ready backpressure:
//     S1 : captures the operand, extracts kept/lsb/guard/sticky, decides inc
//     S2 : adds inc (carry bumps the exponent) and packs the result
//
//   Optional build macro FCVT_ROUND_SP_EN adds in_fmt (0=double, 1=single);
//   single results are NaN-boxed into the upper 32 bits.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready is combinational)
//   in_sign, in_exp   result sign, biased exponent (bias 1023)
//   in_mant           normalized significand, in_mant[MANT_W-1]=1 unless zero
//   in_zero           integer source was 0
//   in_rm             0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 illegal
//   in_fmt            (FCVT_ROUND_SP_EN only) 0=double, 1=single
//   out_valid/out_ready downstream handshake
//   out_fp, out_nx, out_ill  packed result, inexact, illegal rounding mode
// ---------------------------------------------------------------------------
module fcvt_round_stage #(
   parameter int EXP_W  = 11,
   parameter int MANT_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [MANT_W-1:0] in_mant,
   input  logic              in_zero,
   input  logic [2:0]        in_rm,
`ifdef FCVT_ROUND_SP_EN
   input  logic              in_fmt,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_fp,
   output logic              out_nx,
   output logic              out_ill
);

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   // Double -> single exponent rebias: -1023 + 127
   localparam logic [10:0] SP_REBIAS = 11'd896;

   // ---------------- handshake ----------------
   logic s1_valid_q, s1_valid_d;
   logic out_valid_q, out_valid_d;
   logic s1_adv, s2_adv;

   assign s2_adv   = !out_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   // ---------------- S1 state ----------------
   logic        s1_sign_q, s1_sign_d;
   logic [10:0] s1_exp_q,  s1_exp_d;
   logic [51:0] s1_kept_q, s1_kept_d;
   logic        s1_inc_q,  s1_inc_d;
   logic        s1_nx_q,   s1_nx_d;
   logic        s1_zero_q, s1_zero_d;
   logic        s1_ill_q,  s1_ill_d;
`ifdef FCVT_ROUND_SP_EN
   logic        s1_fmt_q,  s1_fmt_d;
`endif

   // ---------------- S2 state ----------------
   logic [63:0] out_fp_q,  out_fp_d;
   logic        out_nx_q,  out_nx_d;
   logic        out_ill_q, out_ill_d;

   // ---------------- S1 extraction ----------------
   logic [51:0] kept;
   logic [10:0] exp_in;
   logic        lsb, grd, stk, inc, ill;

   always_comb begin
      kept   = in_mant[MANT_W-2 -: 52];
      lsb    = in_mant[MANT_W-53];
      grd    = in_mant[MANT_W-54];
      stk    = |in_mant[MANT_W-55:0];
      exp_in = 11'(in_exp);
`ifdef FCVT_ROUND_SP_EN
      if (in_fmt) begin
         // Single keeps 23 fraction bits; left in the low bits so the
         // carry out lands in bit 23 of the S2 sum.
         kept   = {29'd0, in_mant[MANT_W-2 -: 23]};
         lsb    = in_mant[MANT_W-24];
         grd    = in_mant[MANT_W-25];
         stk    = |in_mant[MANT_W-26:0];
         exp_in = 11'(in_exp) - SP_REBIAS;
      end
`endif
      ill = (in_rm > RM_RMM);
      unique case (in_rm)
         RM_RNE:  inc = grd & (stk | lsb);
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = (grd | stk) & in_sign;
         RM_RUP:  inc = (grd | stk) & !in_sign;
         RM_RMM:  inc = grd;
         default: inc = 1'b0;
      endcase
   end

   // ---------------- S2 round/pack ----------------
   logic [52:0] sum;
   logic        carry;
   logic [10:0] exp_r;
   logic [63:0] fp_pack;

   always_comb begin
      sum     = {1'b0, s1_kept_q} + {52'd0, s1_inc_q};
      // All-ones kept plus inc wraps the fraction to zero and bumps exponent
      carry   = sum[52];
      exp_r   = s1_exp_q + {10'd0, carry};
      fp_pack = {s1_sign_q, exp_r, sum[51:0]};
`ifdef FCVT_ROUND_SP_EN
      if (s1_fmt_q) begin
         carry   = sum[23];
         exp_r   = s1_exp_q + {10'd0, carry};
         fp_pack = {32'hFFFF_FFFF, s1_sign_q, exp_r[7:0], sum[22:0]};
      end
`endif
      if (s1_zero_q || s1_ill_q) fp_pack = 64'd0;
   end

   // ---------------- next state ----------------
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_sign_d   = s1_sign_q;
      s1_exp_d    = s1_exp_q;
      s1_kept_d   = s1_kept_q;
      s1_inc_d    = s1_inc_q;
      s1_nx_d     = s1_nx_q;
      s1_zero_d   = s1_zero_q;
      s1_ill_d    = s1_ill_q;
`ifdef FCVT_ROUND_SP_EN
      s1_fmt_d    = s1_fmt_q;
`endif
      out_valid_d = out_valid_q;
      out_fp_d    = out_fp_q;
      out_nx_d    = out_nx_q;
      out_ill_d   = out_ill_q;

      if (s1_adv) begin
         s1_valid_d = in_valid;
         // Data only moves on an actual transfer; bubbles keep old bits
         if (in_valid) begin
            s1_sign_d = in_sign;
            s1_exp_d  = exp_in;
            s1_kept_d = kept;
            s1_inc_d  = inc & !in_zero & !ill;
            s1_nx_d   = (grd | stk) & !in_zero & !ill;
            s1_zero_d = in_zero;
            s1_ill_d  = ill;
`ifdef FCVT_ROUND_SP_EN
            s1_fmt_d  = in_fmt;
`endif
         end
      end

      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_fp_d  = fp_pack;
            out_nx_d  = s1_nx_q;
            out_ill_d = s1_ill_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_exp_q    <= 11'd0;
         s1_kept_q   <= 52'd0;
         s1_inc_q    <= 1'b0;
         s1_nx_q     <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_ill_q    <= 1'b0;
`ifdef FCVT_ROUND_SP_EN
         s1_fmt_q    <= 1'b0;
`endif
         out_valid_q <= 1'b0;
         out_fp_q    <= 64'd0;
         out_nx_q    <= 1'b0;
         out_ill_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_exp_q    <= s1_exp_d;
         s1_kept_q   <= s1_kept_d;
         s1_inc_q    <= s1_inc_d;
         s1_nx_q     <= s1_nx_d;
         s1_zero_q   <= s1_zero_d;
         s1_ill_q    <= s1_ill_d;
`ifdef FCVT_ROUND_SP_EN
         s1_fmt_q    <= s1_fmt_d;
`endif
         out_valid_q <= out_valid_d;
         out_fp_q    <= out_fp_d;
         out_nx_q    <= out_nx_d;
         out_ill_q   <= out_ill_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_fp    = out_fp_q;
   assign out_nx    = out_nx_q;
   assign out_ill   = out_ill_q;

endmodule

// File: tb/tb_fcvt_round_stage.sv
// Directed bench for fcvt_round_stage: table of single-shot vectors with
// hand-computed results, then stall/stream and mid-stream reset sequences.
module tb_fcvt_round_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic        in_sign;
   logic [10:0] in_exp;
   logic [63:0] in_mant;
   logic        in_zero;
   logic [2:0]  in_rm;
   logic        in_fmt;
   logic        out_valid, out_ready;
   logic [63:0] out_fp;
   logic        out_nx, out_ill;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fcvt_round_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .in_zero   (in_zero),
      .in_rm     (in_rm),
`ifdef FCVT_ROUND_SP_EN
      .in_fmt    (in_fmt),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fp    (out_fp),
      .out_nx    (out_nx),
      .out_ill   (out_ill)
   );

   typedef struct {
      string       name;
      logic        sign;
      logic [10:0] exp;
      logic [63:0] mant;
      logic        zero;
      logic [2:0]  rm;
      logic        fmt;
      logic [63:0] fp;
      logic        nx;
      logic        ill;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_sign = v.sign;
      in_exp  = v.exp;
      in_mant = v.mant;
      in_zero = v.zero;
      in_rm   = v.rm;
      in_fmt  = v.fmt;
   endtask

   task automatic add(input string n, input logic s, input logic [10:0] e, input logic [63:0] m,
                      input logic z, input logic [2:0] r, input logic f,
                      input logic [63:0] fp, input logic nx, input logic il);
      vec_t v;
      v.name = n; v.sign = s; v.exp = e; v.mant = m; v.zero = z; v.rm = r; v.fmt = f;
      v.fp = fp; v.nx = nx; v.ill = il;
      vecs.push_back(v);
   endtask

   // One transaction through an otherwise idle pipe; checks 2-cycle latency.
   task automatic apply_vec(input vec_t v);
      @(negedge clk);
      drive(v);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1 chk({v.name, ".in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk({v.name, ".lat1_valid"}, 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk({v.name, ".valid"}, 64'(out_valid), 64'd1);
      chk({v.name, ".fp"},    out_fp,          v.fp);
      chk({v.name, ".nx"},    64'(out_nx),     64'(v.nx));
      chk({v.name, ".ill"},   64'(out_ill),    64'(v.ill));
   endtask

   // Four back-to-back inputs with out_ready held low for STALL cycles.
   task automatic run_stream(input int stall);
      int pi = 0;
      int oi = 0;
      int cyc;
      for (cyc = 0; cyc < 40 && oi < 4; cyc++) begin
         out_ready = (cyc >= stall);
         if (pi < 4) begin
            drive(vecs[pi]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc >= 2 && cyc < stall) begin
            chk($sformatf("stall.in_ready_c%0d", cyc), 64'(in_ready), 64'd0);
            chk($sformatf("stall.hold_fp_c%0d", cyc), out_fp, vecs[0].fp);
            chk($sformatf("stall.hold_valid_c%0d", cyc), 64'(out_valid), 64'd1);
         end
         if (cyc == stall) begin
            // Full pipe draining: accept and drain in the same cycle
            chk("stream.full_in_ready", 64'(in_ready), 64'd1);
            chk("stream.full_out_valid", 64'(out_valid), 64'd1);
         end
         if (out_valid && out_ready) begin
            chk($sformatf("stream.out%0d.fp", oi), out_fp, vecs[oi].fp);
            chk($sformatf("stream.out%0d.nx", oi), 64'(out_nx), 64'(vecs[oi].nx));
            oi++;
         end
         if (in_valid && in_ready) pi++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("stream.count", 64'(oi), 64'd4);
      #1 chk("stream.no_dup", 64'(out_valid), 64'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_sign = 1'b0; in_exp = '0; in_mant = '0; in_zero = 1'b0; in_rm = '0; in_fmt = 1'b0;

      //   name          s  exp     mant                    z  rm  f  fp                      nx  ill
      add("t1_one",      0, 11'd1023, 64'h8000_0000_0000_0000, 0, 0, 0, 64'h3FF0_0000_0000_0000, 0, 0);
      add("t2_neg_one",  1, 11'd1023, 64'h8000_0000_0000_0000, 0, 0, 0, 64'hBFF0_0000_0000_0000, 0, 0);
      add("t3_rne",      0, 11'd1076, 64'h8000_0000_0000_0400, 0, 0, 0, 64'h4340_0000_0000_0000, 1, 0);
      add("t4_rne_carry",0, 11'd1086, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 64'h43F0_0000_0000_0000, 1, 0);
      add("t3_rup",      0, 11'd1076, 64'h8000_0000_0000_0400, 0, 3, 0, 64'h4340_0000_0000_0001, 1, 0);
      add("t3_rmm",      0, 11'd1076, 64'h8000_0000_0000_0400, 0, 4, 0, 64'h4340_0000_0000_0001, 1, 0);
      add("t3_rtz",      0, 11'd1076, 64'h8000_0000_0000_0400, 0, 1, 0, 64'h4340_0000_0000_0000, 1, 0);
      add("t3_rdn_pos",  0, 11'd1076, 64'h8000_0000_0000_0400, 0, 2, 0, 64'h4340_0000_0000_0000, 1, 0);
      add("tie_odd_rne", 0, 11'd1076, 64'h8000_0000_0000_0C00, 0, 0, 0, 64'h4340_0000_0000_0002, 1, 0);
      add("stk_rne",     0, 11'd1076, 64'h8000_0000_0000_0001, 0, 0, 0, 64'h4340_0000_0000_0000, 1, 0);
      add("stk_rup",     0, 11'd1076, 64'h8000_0000_0000_0001, 0, 3, 0, 64'h4340_0000_0000_0001, 1, 0);
      add("t4_rtz",      0, 11'd1086, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 64'h43EF_FFFF_FFFF_FFFF, 1, 0);
      add("t4_rdn_neg",  1, 11'd1086, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2, 0, 64'hC3F0_0000_0000_0000, 1, 0);
      add("t4_rup_neg",  1, 11'd1086, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3, 0, 64'hC3EF_FFFF_FFFF_FFFF, 1, 0);
      add("t5_zero",     1, 11'd1086, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3, 0, 64'h0000_0000_0000_0000, 0, 0);
      add("t5_rm5",      0, 11'd1076, 64'h8000_0000_0000_0400, 0, 5, 0, 64'h0000_0000_0000_0000, 0, 1);
      add("t5_rm7",      1, 11'd1023, 64'h8000_0000_0000_0000, 0, 7, 0, 64'h0000_0000_0000_0000, 0, 1);
`ifdef FCVT_ROUND_SP_EN
      add("sp_one",      0, 11'd1023, 64'h8000_0000_0000_0000, 0, 0, 1, 64'hFFFF_FFFF_3F80_0000, 0, 0);
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.out_fp",    out_fp,         64'd0);
      chk("rst.out_nx",    64'(out_nx),    64'd0);
      chk("rst.out_ill",   64'(out_ill),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("rst.in_ready", 64'(in_ready), 64'd1);

      foreach (vecs[i]) apply_vec(vecs[i]);

      @(negedge clk);
      out_ready = 1'b1;
      #1;
      @(negedge clk);
      run_stream(5);

      // Mid-stream reset: two accepted transactions must never appear
      out_ready = 1'b1;
      drive(vecs[0]); in_valid = 1'b1;
      @(negedge clk);
      drive(vecs[1]);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 chk("midrst.out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1 chk($sformatf("midrst.flush_c%0d", c), 64'(out_valid), 64'd0);
      end
      chk("midrst.in_ready", 64'(in_ready), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
